// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga memory stage: instruction/stage payloads,
// access sizes, FSM states and small address-alignment helpers.
package tartaruga_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [XLEN-1:0] raw;
    logic            is_load;
    logic            is_store;
    mem_size_t       mem_size;
    logic            mem_unsigned;
  } instr_t;

  typedef struct packed {
    logic            valid;
    instr_t          instr;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] data_rs2;
    logic            branch_taken;
  } exe_to_mem_t;

  typedef struct packed {
    logic            valid;
    instr_t          instr;
    logic [XLEN-1:0] result;
    logic            branch_taken;
    logic            misaligned;
  } mem_to_wb_t;

  // True when the low address bits are illegal for the access size.
  function automatic logic addr_misaligned(input mem_size_t size, input logic [1:0] off);
    case (size)
      HALF:    return off[0];
      WORD:    return |off;
      default: return 1'b0;
    endcase
  endfunction

  // Byte offset with the offending low bits cleared for the access size.
  function automatic logic [1:0] align_offset(input mem_size_t size, input logic [1:0] off);
    case (size)
      HALF:    return {off[1], 1'b0};
      WORD:    return 2'b00;
      default: return off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables / replicated write data,
// and load lane extraction with sign or zero extension.
module lsu_align
  import tartaruga_pkg::*;
(
  input  mem_size_t       size,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_word,
  input  logic            is_unsigned,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0] lane;

  always_comb begin
    be    = '0;
    wdata = store_data;
    case (size)
      BYTE: begin
        be    = BE_W'(1) << offset;
        wdata = {4{store_data[7:0]}};
      end
      HALF: begin
        be    = offset[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0 before extending.
  always_comb begin
    lane      = load_word >> {offset, 3'b000};
    load_data = load_word;
    case (size)
      BYTE:    load_data = is_unsigned ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      HALF:    load_data = is_unsigned ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU results through in one cycle and runs
// loads/stores over a req/ready + rsp_valid data-memory port.
// Optional build macro: MEM_MISALIGN_TRAP_EN (trap misaligned half/word accesses).
module mem_stage
  import tartaruga_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  exe_to_mem_t     exe_to_mem_i,
  output logic            stall_o,
  output logic            dmem_req_o,
  input  logic            dmem_ready_i,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic            dmem_we_o,
  output logic [BE_W-1:0] dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_rsp_valid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output mem_to_wb_t      mem_to_wb_o
);

  mem_state_t      state_q, state_d;
  mem_to_wb_t      wb_q, wb_d;

  logic [XLEN-1:0] addr_q;
  mem_size_t       size_q;
  logic            uns_q;
  logic [XLEN-1:0] data_q;
  logic            we_q;
  instr_t          instr_q;
  logic            branch_q;

  logic            accept;
  logic            is_mem;
  logic            trap;
  logic            latch_en;
  logic [XLEN-1:0] eff_addr;
  logic [BE_W-1:0] be_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] load_data_c;

  assign accept = (state_q == IDLE) & exe_to_mem_i.valid;
  assign is_mem = exe_to_mem_i.instr.is_load | exe_to_mem_i.instr.is_store;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap     = is_mem & addr_misaligned(exe_to_mem_i.instr.mem_size, exe_to_mem_i.result[1:0]);
  assign eff_addr = exe_to_mem_i.result;
`else
  assign trap     = 1'b0;
  assign eff_addr = {exe_to_mem_i.result[XLEN-1:2],
                     align_offset(exe_to_mem_i.instr.mem_size, exe_to_mem_i.result[1:0])};
`endif

  assign latch_en = accept & is_mem & ~trap;

  lsu_align u_align (
    .size        (size_q),
    .offset      (addr_q[1:0]),
    .store_data  (data_q),
    .load_word   (dmem_rdata_i),
    .is_unsigned (uns_q),
    .be          (be_c),
    .wdata       (wdata_c),
    .load_data   (load_data_c)
  );

  assign stall_o      = (state_q != IDLE) | (accept & is_mem);
  assign dmem_req_o   = (state_q == REQ);
  assign dmem_addr_o  = {addr_q[XLEN-1:2], 2'b00};
  assign dmem_we_o    = we_q;
  assign dmem_be_o    = dmem_req_o ? be_c : '0;
  assign dmem_wdata_o = wdata_c;
  assign mem_to_wb_o  = wb_q;

  // Next state and next writeback payload.
  always_comb begin
    state_d = state_q;
    wb_d    = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mem && !trap) begin
            state_d = REQ;
          end else begin
            wb_d.valid        = 1'b1;
            wb_d.instr        = exe_to_mem_i.instr;
            wb_d.branch_taken = exe_to_mem_i.branch_taken;
            wb_d.result       = is_mem ? '0 : exe_to_mem_i.result;
            wb_d.misaligned   = trap;
          end
        end
      end
      REQ: begin
        if (dmem_ready_i) begin
          if (we_q) begin
            state_d           = IDLE;
            wb_d.valid        = 1'b1;
            wb_d.instr        = instr_q;
            wb_d.branch_taken = branch_q;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_rsp_valid_i) begin
          state_d           = IDLE;
          wb_d.valid        = 1'b1;
          wb_d.instr        = instr_q;
          wb_d.branch_taken = branch_q;
          wb_d.result       = load_data_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wb_q     <= '0;
      addr_q   <= '0;
      size_q   <= BYTE;
      uns_q    <= 1'b0;
      data_q   <= '0;
      we_q     <= 1'b0;
      instr_q  <= '0;
      branch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
      if (latch_en) begin
        addr_q   <= eff_addr;
        size_q   <= exe_to_mem_i.instr.mem_size;
        uns_q    <= exe_to_mem_i.instr.mem_unsigned;
        data_q   <= exe_to_mem_i.data_rs2;
        we_q     <= ~exe_to_mem_i.instr.is_load;
        instr_q  <= exe_to_mem_i.instr;
        branch_q <= exe_to_mem_i.branch_taken;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// ALU/load/store traffic checked against a byte-level reference model.
module tb_mem_stage;
  import tartaruga_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  exe_to_mem_t exe;
  logic        stall_o;
  logic        dmem_req_o;
  logic        dmem_ready_i;
  logic [31:0] dmem_addr_o;
  logic        dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_rsp_valid_i;
  logic [31:0] dmem_rdata_i;
  mem_to_wb_t  wb;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mem_stage dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .exe_to_mem_i     (exe),
    .stall_o          (stall_o),
    .dmem_req_o       (dmem_req_o),
    .dmem_ready_i     (dmem_ready_i),
    .dmem_addr_o      (dmem_addr_o),
    .dmem_we_o        (dmem_we_o),
    .dmem_be_o        (dmem_be_o),
    .dmem_wdata_o     (dmem_wdata_o),
    .dmem_rsp_valid_i (dmem_rsp_valid_i),
    .dmem_rdata_i     (dmem_rdata_i),
    .mem_to_wb_o      (wb)
  );

  task automatic next_cycle;
    @(posedge clk_i);
    #1;
  endtask

  function automatic exe_to_mem_t mk(input logic ld, input logic st, input mem_size_t sz,
                                     input logic uns, input logic [31:0] res,
                                     input logic [31:0] data, input logic bt);
    exe_to_mem_t e;
    e.valid              = 1'b1;
    e.instr.raw          = $urandom;
    e.instr.is_load      = ld;
    e.instr.is_store     = st;
    e.instr.mem_size     = sz;
    e.instr.mem_unsigned = uns;
    e.result             = res;
    e.data_rs2           = data;
    e.branch_taken       = bt;
    return e;
  endfunction

  // Byte-level reference: memory sees a word address; the access covers
  // nbytes lanes starting at the (size-aligned) byte offset.
  function automatic void ref_access(input logic ld, input mem_size_t sz, input logic uns,
                                     input logic [31:0] addr, input logic [31:0] data,
                                     input logic [31:0] rdata,
                                     output logic [31:0] eaddr, output logic [31:0] ewdata,
                                     output logic [31:0] eres, output logic [3:0] ebe);
    int nbytes;
    int off;
    longint v;
    nbytes = (sz == BYTE) ? 1 : (sz == HALF) ? 2 : 4;
    off    = int'(addr % 4);
    off    = off - (off % nbytes);
    eaddr  = (addr / 4) * 4;
    ebe    = '0;
    for (int k = 0; k < nbytes; k++) ebe[off + k] = 1'b1;
    for (int l = 0; l < 4; l++) ewdata[8*l +: 8] = data[8*(l % nbytes) +: 8];
    v = 0;
    for (int k = 0; k < nbytes; k++) v = v + (longint'(rdata[8*(off+k) +: 8]) << (8*k));
    if (!uns && v >= (longint'(1) << (8*nbytes - 1))) v = v - (longint'(1) << (8*nbytes));
    eres = ld ? 32'(v) : 32'h0;
  endfunction

  task automatic test_reset;
    rst_i = 1'b1;
    exe = '0;
    dmem_ready_i = 1'b0;
    dmem_rsp_valid_i = 1'b0;
    dmem_rdata_i = '0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({stall_o, dmem_req_o, wb.valid, wb.misaligned} !== 4'b0000)
      $display("FAIL reset_outputs got %b exp 0000", {stall_o, dmem_req_o, wb.valid, wb.misaligned});
    checks++;
    if (wb !== '0) $display("FAIL reset_wb got %h exp 0", wb);
    if (wb !== '0) errors++;
    if ({stall_o, dmem_req_o, wb.valid, wb.misaligned} !== 4'b0000) errors++;
    next_cycle;
    rst_i = 1'b0;
    next_cycle;
  endtask

  task automatic test_alu(input logic [31:0] res);
    exe_to_mem_t e;
    e = mk(1'b0, 1'b0, BYTE, 1'b0, res, $urandom, 1'($urandom));
    exe = e;
    @(negedge clk_i);
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL alu_stall got %b exp 0", stall_o); end
    next_cycle;
    exe.valid = 1'b0;
    @(negedge clk_i);
    checks++;
    if (wb.valid !== 1'b1 || wb.result !== res || wb.instr !== e.instr ||
        wb.branch_taken !== e.branch_taken || wb.misaligned !== 1'b0) begin
      errors++;
      $display("FAIL alu_out got v=%b r=%h exp v=1 r=%h", wb.valid, wb.result, res);
    end
    next_cycle;
    @(negedge clk_i);
    checks++;
    if (wb.valid !== 1'b0) begin errors++; $display("FAIL alu_pulse got %b exp 0", wb.valid); end
  endtask

  task automatic run_mem(input logic ld, input mem_size_t sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] data,
                         input int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
                         output logic [31:0] got_res);
    exe_to_mem_t e;
    logic [31:0] eaddr, ewdata, eres;
    logic [3:0]  ebe;
    ref_access(ld, sz, uns, addr, data, rdata, eaddr, ewdata, eres, ebe);
    e = mk(ld, ~ld, sz, uns, addr, data, 1'($urandom));
    exe = e;
    @(negedge clk_i);
    checks++;
    if (stall_o !== 1'b1 || dmem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL mem_accept got stall=%b req=%b exp stall=1 req=0", stall_o, dmem_req_o);
    end
    next_cycle;
    exe = mk(1'b0, 1'b0, BYTE, 1'b0, $urandom, $urandom, 1'b0);
    exe.valid = 1'b0;
    for (int i = 0; i <= rdy_dly; i++) begin
      dmem_ready_i = (i == rdy_dly);
      dmem_rsp_valid_i = 1'($urandom);
      dmem_rdata_i = $urandom;
      @(negedge clk_i);
      checks++;
      if (dmem_req_o !== 1'b1 || dmem_addr_o !== eaddr || dmem_we_o !== ~ld ||
          dmem_be_o !== ebe || (!ld && dmem_wdata_o !== ewdata) ||
          stall_o !== 1'b1 || wb.valid !== 1'b0) begin
        errors++;
        $display("FAIL req_phase got req=%b a=%h we=%b be=%b wd=%h st=%b v=%b exp req=1 a=%h we=%b be=%b wd=%h st=1 v=0",
                 dmem_req_o, dmem_addr_o, dmem_we_o, dmem_be_o, dmem_wdata_o, stall_o, wb.valid,
                 eaddr, ~ld, ebe, ewdata);
      end
      next_cycle;
    end
    dmem_ready_i = 1'b0;
    if (ld) begin
      for (int i = 0; i <= rsp_dly; i++) begin
        dmem_rsp_valid_i = (i == rsp_dly);
        dmem_rdata_i = (i == rsp_dly) ? rdata : $urandom;
        @(negedge clk_i);
        checks++;
        if (dmem_req_o !== 1'b0 || stall_o !== 1'b1 || wb.valid !== 1'b0) begin
          errors++;
          $display("FAIL wait_phase got req=%b st=%b v=%b exp 0 1 0", dmem_req_o, stall_o, wb.valid);
        end
        next_cycle;
      end
    end
    dmem_rsp_valid_i = 1'($urandom);
    dmem_rdata_i = $urandom;
    @(negedge clk_i);
    got_res = wb.result;
    checks++;
    if (wb.valid !== 1'b1 || wb.result !== eres || wb.instr !== e.instr ||
        wb.branch_taken !== e.branch_taken || wb.misaligned !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL mem_out got v=%b r=%h st=%b exp v=1 r=%h st=0", wb.valid, wb.result, stall_o, eres);
    end
    next_cycle;
    dmem_rsp_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (wb.valid !== 1'b0 || dmem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL mem_pulse got v=%b req=%b exp 0 0", wb.valid, dmem_req_o);
    end
  endtask

  task automatic test_loads_stores;
    logic [31:0] r;
    next_cycle;
    run_mem(1'b1, BYTE, 1'b0, 32'h103, 32'h0, 0, 0, 32'h80FF_FF00, r);
    checks++;
    if (r !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_value got %h exp ffffff80", r); end
    next_cycle;
    run_mem(1'b1, BYTE, 1'b1, 32'h103, 32'h0, 0, 0, 32'h80FF_FF00, r);
    checks++;
    if (r !== 32'h0000_0080) begin errors++; $display("FAIL lbu_value got %h exp 00000080", r); end
    next_cycle;
    run_mem(1'b0, HALF, 1'b0, 32'h102, 32'h0000_ABCD, 3, 0, 32'h0, r);
    next_cycle;
    run_mem(1'b1, HALF, 1'b0, 32'h202, 32'h0, 2, 3, 32'h8001_7FFF, r);
    checks++;
    if (r !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_value got %h exp ffff8001", r); end
    next_cycle;
  endtask

  task automatic test_misalign;
`ifdef MEM_MISALIGN_TRAP_EN
    exe_to_mem_t e;
    e = mk(1'b1, 1'b0, WORD, 1'b0, 32'h101, 32'h0, 1'b1);
    exe = e;
    @(negedge clk_i);
    checks++;
    if (dmem_req_o !== 1'b0) begin errors++; $display("FAIL trap_noreq_a got %b exp 0", dmem_req_o); end
    next_cycle;
    exe.valid = 1'b0;
    @(negedge clk_i);
    checks++;
    if (wb.valid !== 1'b1 || wb.misaligned !== 1'b1 || wb.result !== 32'h0 ||
        dmem_req_o !== 1'b0 || stall_o !== 1'b0 || wb.instr !== e.instr) begin
      errors++;
      $display("FAIL trap_out got v=%b mis=%b r=%h req=%b st=%b exp 1 1 0 0 0",
               wb.valid, wb.misaligned, wb.result, dmem_req_o, stall_o);
    end
    next_cycle;
    @(negedge clk_i);
    checks++;
    if (wb.valid !== 1'b0 || dmem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL trap_pulse got v=%b req=%b exp 0 0", wb.valid, dmem_req_o);
    end
    next_cycle;
`else
    logic [31:0] r;
    run_mem(1'b1, WORD, 1'b0, 32'h101, 32'h0, 0, 1, 32'h1234_5678, r);
    checks++;
    if (r !== 32'h1234_5678) begin errors++; $display("FAIL lw_forced got %h exp 12345678", r); end
    next_cycle;
`endif
  endtask

  task automatic test_reset_in_wait;
    exe = mk(1'b1, 1'b0, WORD, 1'b0, 32'h300, 32'h0, 1'b0);
    next_cycle;
    exe.valid = 1'b0;
    dmem_ready_i = 1'b1;
    next_cycle;
    dmem_ready_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({stall_o, dmem_req_o, wb.valid} !== 3'b000) begin
      errors++;
      $display("FAIL rst_wait got %b exp 000", {stall_o, dmem_req_o, wb.valid});
    end
    next_cycle;
    rst_i = 1'b0;
    dmem_rsp_valid_i = 1'b1;
    dmem_rdata_i = $urandom;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      checks++;
      if ({stall_o, dmem_req_o, wb.valid} !== 3'b000) begin
        errors++;
        $display("FAIL rst_late_rsp got %b exp 000", {stall_o, dmem_req_o, wb.valid});
      end
      next_cycle;
    end
    dmem_rsp_valid_i = 1'b0;
    test_alu(32'hCAFE_0001);
    next_cycle;
  endtask

  task automatic test_back_to_back;
    exe_to_mem_t lw, alu;
    logic [31:0] rd;
    rd  = $urandom;
    lw  = mk(1'b1, 1'b0, WORD, 1'b0, 32'h400, 32'h0, 1'b1);
    alu = mk(1'b0, 1'b0, BYTE, 1'b0, $urandom, 32'h0, 1'b0);
    exe = lw;
    next_cycle;
    exe = alu;
    dmem_ready_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (stall_o !== 1'b1 || wb.valid !== 1'b0 || dmem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_req got st=%b v=%b req=%b exp 1 0 1", stall_o, wb.valid, dmem_req_o);
    end
    next_cycle;
    dmem_ready_i = 1'b0;
    dmem_rsp_valid_i = 1'b1;
    dmem_rdata_i = rd;
    @(negedge clk_i);
    checks++;
    if (stall_o !== 1'b1 || wb.valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_wait got st=%b v=%b exp 1 0", stall_o, wb.valid);
    end
    next_cycle;
    dmem_rsp_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (wb.valid !== 1'b1 || wb.result !== rd || wb.instr !== lw.instr || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_lw got v=%b r=%h st=%b exp 1 %h 0", wb.valid, wb.result, stall_o, rd);
    end
    next_cycle;
    exe.valid = 1'b0;
    @(negedge clk_i);
    checks++;
    if (wb.valid !== 1'b1 || wb.result !== alu.result || wb.instr !== alu.instr) begin
      errors++;
      $display("FAIL b2b_alu got v=%b r=%h exp 1 %h", wb.valid, wb.result, alu.result);
    end
    next_cycle;
    @(negedge clk_i);
    checks++;
    if (wb.valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse got %b exp 0", wb.valid); end
    next_cycle;
  endtask

  task automatic test_random;
    logic [31:0] r, addr;
    mem_size_t   sz;
    int          kind, nb;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      sz   = mem_size_t'(2'($urandom_range(0, 2)));
      addr = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
      nb   = (sz == BYTE) ? 1 : (sz == HALF) ? 2 : 4;
      addr = addr - (addr % nb);
`else
      nb   = 0;
`endif
      if (kind == 0) test_alu($urandom);
      else run_mem(kind == 1, sz, 1'($urandom), addr, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom, r);
      next_cycle;
    end
  endtask

  initial begin
    test_reset;
    test_alu(32'h0000_1234);
    next_cycle;
    test_loads_stores;
    test_misalign;
    test_reset_in_wait;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Ports SHALL be:
- clk_i  in  1  sole clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- exe_to_mem_i  in  exe_to_mem_t  valid, instr, result (address or ALU value), data_rs2, branch_taken
- stall_o  out  1  upstream must hold exe_to_mem_i
- dmem_req_o  out  1  data-memory request valid
- dmem_ready_i  in  1  request accepted this cycle
- dmem_addr_o  out  32  word-aligned address
- dmem_we_o  out  1  1 = store
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-positioned store data
- dmem_rsp_valid_i  in  1  load data valid
- dmem_rdata_i  in  32  load word
- mem_to_wb_o  out  mem_to_wb_t  valid, instr, result, branch_taken, misaligned

Function
REQ-002 Instruction accepted when exe_to_mem_i.valid=1 and state=IDLE.
REQ-003 Non-memory instruction: mem_to_wb_o registered next cycle with result = exe_to_mem_i.result; latency 1; no stall.
REQ-004 FSM states IDLE, REQ, WAIT; memory instruction accepted in IDLE -> REQ, with address, size, signedness, store data latched.
REQ-005 REQ: dmem_req_o=1 with stable addr/we/be/wdata until dmem_ready_i=1; store -> IDLE, load -> WAIT.
REQ-006 Store: mem_to_wb_o.valid pulses the cycle after the handshake, result=0.
REQ-007 WAIT: on dmem_rsp_valid_i=1 capture load, mem_to_wb_o.valid pulses next cycle, -> IDLE.
REQ-008 dmem_rsp_valid_i outside WAIT SHALL be ignored; earliest honoured response is the cycle after the accepting handshake.
REQ-009 stall_o = (state != IDLE) | (state==IDLE & valid memory instruction accepted this cycle), combinational.
REQ-010 Sizes: byte (be = 1<<addr[1:0]), half (be = 0011 or 1100 by addr[1]), word (be=1111); wdata replicated across lanes.
REQ-011 Load extraction selects lane by addr[1:0]; signed loads sign-extend, unsigned zero-extend to 32 bits.
REQ-012 branch_taken and instr forwarded unchanged into mem_to_wb_o.
REQ-013 mem_to_wb_o.valid SHALL be high exactly one cycle per accepted instruction; zero otherwise.

Reset
REQ-014 On rst_i: state=IDLE, dmem_req_o=0, mem_to_wb_o.valid=0, misaligned=0, stall_o=0, all latched data=0.
REQ-015 Reset mid-transaction abandons it; no mem_to_wb_o output for it; late dmem_rsp_valid_i after reset ignored.

Configuration
REQ-016 MEM_MISALIGN_TRAP_EN defined: half at odd address or word with addr[1:0]!=0 issues no request, mem_to_wb_o.valid pulses next cycle with misaligned=1, result=0.
REQ-017 MEM_MISALIGN_TRAP_EN undefined: offending low address bits forced to zero (half: addr[0], word: addr[1:0]), access proceeds, misaligned tied 0.

Structure
REQ-018 tartaruga_pkg SHALL hold mem_to_wb_t, mem_size_t (BYTE, HALF, WORD), mem_state_t, and is_load/is_store/mem_size/mem_unsigned fields in the instruction type.
REQ-019 Combinational sub-module lsu_align SHALL produce be/wdata from size, addr, data and extended load data from size, signedness, addr, rdata.

Verification
REQ-020 ALU instr, result=0x1234 -> mem_to_wb_o.valid next cycle, result=0x1234, stall_o=0.
REQ-021 LB addr=0x103, rdata=0x80FF_FF00, ready and rsp each 1 cycle later -> result=0xFFFF_FF80; LBU -> 0x0000_0080.
REQ-022 SH addr=0x102, data_rs2=0xABCD, ready held low 3 cycles -> dmem_req_o held 4 cycles, be=1100, wdata=0xABCD_ABCD, stall_o high throughout.
REQ-023 LW addr=0x101: with MEM_MISALIGN_TRAP_EN -> no dmem_req_o, misaligned=1; without -> dmem_addr_o=0x100.
REQ-024 rst_i asserted in WAIT, then dmem_rsp_valid_i=1 -> no mem_to_wb_o.valid, state IDLE.
REQ-025 Back-to-back LW, ALU -> ALU held by stall_o, outputs in order, each valid exactly one cycle.
